// File: rtl/btn_cond_pkg.sv
// Shared defaults and sizing helper for the button/switch conditioning front-end.
package btn_cond_pkg;

  localparam int N_BTN_DEF           = 4;
  localparam int N_SW_DEF            = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1250000;  // 10 ms at 125 MHz
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  // Counter width that holds 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: two-flop synchronizer, stable-level register with run-length
// debounce counter, and a registered one-cycle pulse on each accepted press.
module debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_125,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic s1;
  (* ASYNC_REG = "TRUE" *) logic s2;
  logic             q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  assign cnt_done = (cnt == CNT_MAX);
  assign level    = q;

  // NOTE: non-blocking assignments keep s1->s2 as two distinct flops and let every
  // register below sample the pre-edge values of its neighbours.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      q     <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= ~q & s2 & cnt_done;
      // Any return to agreement restarts the run, so glitches never move q.
      if (s2 == q) begin
        cnt <= '0;
      end else if (cnt_done) begin
        q   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Synchronizes and debounces board buttons, synchronizes switches, into clk_125.
// BTN_CONDITIONER_PULSE_EN: when defined btn_out carries press pulses, else debounced levels.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int N_SW            = N_SW_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk_125,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_out,
  output logic [N_SW-1:0]  sw_out
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_125(clk_125),
      .rst_n  (rst_n),
      .raw    (btn_in[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i])
    );
  end

  // Switches are level controls; synchronizing is enough, no debounce.
  (* ASYNC_REG = "TRUE" *) logic [N_SW-1:0] sw_s1;
  (* ASYNC_REG = "TRUE" *) logic [N_SW-1:0] sw_s2;

  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
    end
  end

  assign sw_out = sw_s2;

`ifdef BTN_CONDITIONER_PULSE_EN
  assign btn_out = btn_press;
`else
  assign btn_out = btn_level;
`endif

endmodule
